// File: rtl/uart_rx_hub_if.sv
// Output byte stream of the UART receive hub: data tagged with its source channel,
// moved with a valid/ready handshake.
interface uart_rx_hub_if #(
  parameter int CH_W = 1
);
  logic [7:0]      out_data;
  logic [CH_W-1:0] out_channel;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output out_data,
    output out_channel,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_channel,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_hub.sv
// Multi-channel 8N1 UART receive hub: per-channel deserialiser and FIFO, merged by a
// round-robin arbiter into one valid/ready byte stream with sticky error flags.
module uart_rx_hub #(
  parameter int NUM_CH     = 2,
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] rxd,
  input  logic [NUM_CH-1:0] ch_enable,
  uart_rx_hub_if.master     out_if,
  output logic [NUM_CH-1:0] overflow,
  output logic [NUM_CH-1:0] framing_err,
  input  logic              clear_status
);
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int AW           = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} rx_state_t;

  logic [NUM_CH-1:0]      nonempty;
  logic [NUM_CH-1:0]      pop;
  logic [NUM_CH-1:0][7:0] head_data;

  logic            out_valid_reg;
  logic [7:0]      out_data_reg;
  logic [CH_W-1:0] out_channel_reg;
  logic [CH_W-1:0] last_grant_reg;
  logic [CH_W-1:0] grant_ch;
  logic            grant_valid;
  logic            load_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             sync1_reg, sync2_reg;
      rx_state_t        state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [2:0]       bit_reg, bit_next;
      logic [7:0]       shift_reg, shift_next;
      logic             push, ferr_set;
      logic [7:0]       mem [FIFO_DEPTH];
      logic [AW:0]      wr_ptr_reg, rd_ptr_reg, wr_seen_reg, rd_ptr_next;
      logic [7:0]       head_reg;
      logic             full, accept;
      logic             ovf_reg, ferr_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
        end else begin
          sync1_reg <= rxd[gi];
          sync2_reg <= sync1_reg;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= WAIT_IDLE;
          cnt_reg   <= '0;
          bit_reg   <= '0;
          shift_reg <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          bit_reg   <= bit_next;
          shift_reg <= shift_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        bit_next   = bit_reg;
        shift_next = shift_reg;
        push       = 1'b0;
        ferr_set   = 1'b0;
        if (!ch_enable[gi]) begin
          state_next = WAIT_IDLE;
        end else begin
          case (state_reg)
            WAIT_IDLE: if (sync2_reg) state_next = IDLE;
            IDLE: begin
              cnt_next = '0;
              if (!sync2_reg) state_next = START;
            end
            START: if (cnt_reg == CNT_W'(HALF_BIT - 1)) begin
              cnt_next   = '0;
              bit_next   = '0;
              state_next = sync2_reg ? IDLE : DATA;
            end
            DATA: if (cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
              cnt_next   = '0;
              shift_next = {sync2_reg, shift_reg[7:1]};
              bit_next   = bit_reg + 3'd1;
              if (bit_reg == 3'd7) state_next = STOP;
            end
            STOP: if (cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
              cnt_next = '0;
              if (sync2_reg) begin
                push       = 1'b1;
                state_next = IDLE;
              end else begin
                ferr_set   = 1'b1;
                state_next = WAIT_IDLE;
              end
            end
            default: state_next = WAIT_IDLE;
          endcase
        end
      end

      // A full FIFO still takes a byte when its head is popped in the same cycle.
      assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                           (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign accept      = push && (!full || pop[gi]);
      assign rd_ptr_next = pop[gi] ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg  <= '0;
          rd_ptr_reg  <= '0;
          wr_seen_reg <= '0;
        end else begin
          if (accept) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
          rd_ptr_reg  <= rd_ptr_next;
          wr_seen_reg <= wr_ptr_reg;
        end
      end

      // The read side tracks a one-cycle-late write pointer so the registered head
      // word is always valid whenever the FIFO reports non-empty.
      always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
        head_reg <= mem[rd_ptr_next[AW-1:0]];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_reg  <= 1'b0;
          ferr_reg <= 1'b0;
        end else begin
          if (push && !accept) ovf_reg <= 1'b1;
          else if (clear_status) ovf_reg <= 1'b0;
          if (ferr_set) ferr_reg <= 1'b1;
          else if (clear_status) ferr_reg <= 1'b0;
        end
      end

      assign nonempty[gi]    = (wr_seen_reg != rd_ptr_reg);
      assign head_data[gi]   = head_reg;
      assign pop[gi]         = load_en && grant_valid && (grant_ch == CH_W'(gi));
      assign overflow[gi]    = ovf_reg;
      assign framing_err[gi] = ferr_reg;
    end
  endgenerate

  always_comb begin
    int idx;
    logic [CH_W-1:0] sel;
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    sel         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(last_grant_reg) + 1 + i) % NUM_CH;
      sel = CH_W'(idx);
      if (!grant_valid && nonempty[sel]) begin
        grant_valid = 1'b1;
        grant_ch    = sel;
      end
    end
  end

  assign load_en = !out_valid_reg || out_if.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_channel_reg <= '0;
      last_grant_reg  <= CH_W'(NUM_CH - 1);
    end else if (load_en) begin
      out_valid_reg <= grant_valid;
      if (grant_valid) begin
        out_data_reg    <= head_data[grant_ch];
        out_channel_reg <= grant_ch;
        last_grant_reg  <= grant_ch;
      end
    end
  end

  assign out_if.out_valid   = out_valid_reg;
  assign out_if.out_data    = out_data_reg;
  assign out_if.out_channel = out_channel_reg;
endmodule

// File: tb/tb_uart_rx_hub.sv
// Directed self-checking bench for uart_rx_hub, run at 16 clocks per bit so every
// scenario (including an 18-byte overflow burst) stays short.
module tb_uart_rx_hub;
  localparam int NUM_CH     = 2;
  localparam int CLK_HZ     = 1600000;
  localparam int BAUD       = 100000;
  localparam int FIFO_DEPTH = 16;
  localparam int CPB        = CLK_HZ / BAUD;
  // 2 sync stages + detection edge + 9.5 bit times + FIFO and output stages
  localparam int LATENCY    = 157;

  typedef struct {
    int ch;
    int data;
    int cyc;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] rxd;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] overflow;
  logic [NUM_CH-1:0] framing_err;
  logic              clear_status;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    start_cyc [NUM_CH];
  beat_t q [$];

  uart_rx_hub_if #(.CH_W(1)) out_if ();

  uart_rx_hub #(
    .NUM_CH(NUM_CH), .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .ch_enable(ch_enable), .out_if(out_if),
    .overflow(overflow), .framing_err(framing_err), .clear_status(clear_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && out_if.out_valid && out_if.out_ready) begin
      beat_t b;
      b.ch = int'(out_if.out_channel);
      b.data = int'(out_if.out_data);
      b.cyc = cyc;
      q.push_back(b);
      $display("beat ch=%0d data=%02h cyc=%0d", b.ch, b.data, b.cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input int ch, input logic [7:0] d, input logic stop);
    @(negedge clk);
    start_cyc[ch] = cyc;
    rxd[ch] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd[ch] = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd[ch] = stop;
    repeat (CPB) @(negedge clk);
    rxd[ch] = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    while (q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rxd = '1; ch_enable = '1; clear_status = 1'b0; out_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (out_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", out_if.out_valid); end
    if (out_if.out_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %02h want 00", out_if.out_data); end
    if (out_if.out_channel !== 1'b0) begin bad++; $display("FAIL rst_channel: got %0d want 0", out_if.out_channel); end
    if (overflow !== 2'b00) begin bad++; $display("FAIL rst_overflow: got %b want 00", overflow); end
    if (framing_err !== 2'b00) begin bad++; $display("FAIL rst_framing: got %b want 00", framing_err); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    q.delete();
  endtask

  task automatic test_single();
    q.delete();
    send_frame(0, 8'hA5, 1'b1);
    wait_beats(1, 100);
    repeat (50) @(negedge clk);
    total++;
    if (q.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", q.size()); end
    if (q.size() >= 1) begin
      total += 3;
      if (q[0].data != 8'hA5) begin bad++; $display("FAIL single_data: got %02h want a5", q[0].data); end
      if (q[0].ch != 0) begin bad++; $display("FAIL single_ch: got %0d want 0", q[0].ch); end
      if (q[0].cyc - start_cyc[0] != LATENCY) begin
        bad++; $display("FAIL single_latency: got %0d want %0d", q[0].cyc - start_cyc[0], LATENCY);
      end
    end
    total++;
    if ({overflow, framing_err} !== 4'b0000) begin bad++; $display("FAIL single_flags: got %b want 0000", {overflow, framing_err}); end
  endtask

  task automatic test_round_robin();
    logic [7:0] d0 [2];
    logic [7:0] d1 [2];
    d0[0] = 8'h11; d1[0] = 8'h22; d0[1] = 8'h33; d1[1] = 8'h44;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      q.delete();
      fork
        send_frame(0, d0[r], 1'b1);
        send_frame(1, d1[r], 1'b1);
      join
      wait_beats(2, 100);
      repeat (20) @(negedge clk);
      total++;
      if (q.size() != 2) begin bad++; $display("FAIL rr%0d_count: got %0d want 2", r, q.size()); end
      if (q.size() >= 2) begin
        total += 3;
        if (q[0].ch != 0 || q[0].data != int'(d0[r])) begin
          bad++; $display("FAIL rr%0d_first: got ch%0d/%02h want ch0/%02h", r, q[0].ch, q[0].data, d0[r]);
        end
        if (q[1].ch != 1 || q[1].data != int'(d1[r])) begin
          bad++; $display("FAIL rr%0d_second: got ch%0d/%02h want ch1/%02h", r, q[1].ch, q[1].data, d1[r]);
        end
        if (q[1].cyc != q[0].cyc + 1) begin
          bad++; $display("FAIL rr%0d_b2b: got gap %0d want 1", r, q[1].cyc - q[0].cyc);
        end
      end
    end
  endtask

  task automatic test_overflow();
    q.delete();
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 18; i++) send_frame(0, 8'(i), 1'b1);
    repeat (20) @(negedge clk);
    total += 3;
    if (overflow !== 2'b01) begin bad++; $display("FAIL ovf_flag: got %b want 01", overflow); end
    if (out_if.out_valid !== 1'b1) begin bad++; $display("FAIL ovf_stall_valid: got %0b want 1", out_if.out_valid); end
    if (out_if.out_data !== 8'h00) begin bad++; $display("FAIL ovf_stall_data: got %02h want 00", out_if.out_data); end
    repeat (30) @(negedge clk);
    total++;
    if (out_if.out_data !== 8'h00 || out_if.out_channel !== 1'b0) begin
      bad++; $display("FAIL ovf_stable: got ch%0d/%02h want ch0/00", out_if.out_channel, out_if.out_data);
    end
    out_if.out_ready = 1'b1;
    wait_beats(17, 200);
    repeat (30) @(negedge clk);
    total++;
    if (q.size() != 17) begin bad++; $display("FAIL ovf_drain_count: got %0d want 17", q.size()); end
    for (int i = 0; i < q.size() && i < 17; i++) begin
      total++;
      if (q[i].data != i || q[i].ch != 0) begin
        bad++; $display("FAIL ovf_drain_%0d: got ch%0d/%02h want ch0/%02h", i, q[i].ch, q[i].data, i);
      end
    end
    pulse_clear();
    total++;
    if (overflow !== 2'b00) begin bad++; $display("FAIL ovf_clear: got %b want 00", overflow); end
  endtask

  task automatic test_framing();
    q.delete();
    fork
      send_frame(1, 8'h55, 1'b0);
      begin
        // clear_status lands on the same edge as the stop-bit sample
        @(negedge clk);
        repeat (LATENCY - 3) @(negedge clk);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    total += 2;
    if (framing_err !== 2'b10) begin bad++; $display("FAIL ferr_flag: got %b want 10", framing_err); end
    if (q.size() != 0) begin bad++; $display("FAIL ferr_nobyte: got %0d want 0", q.size()); end
    send_frame(1, 8'h3C, 1'b1);
    wait_beats(1, 100);
    total++;
    if (q.size() != 1) begin bad++; $display("FAIL ferr_recover_count: got %0d want 1", q.size()); end
    if (q.size() >= 1) begin
      total++;
      if (q[0].data != 8'h3C || q[0].ch != 1) begin
        bad++; $display("FAIL ferr_recover: got ch%0d/%02h want ch1/3c", q[0].ch, q[0].data);
      end
    end
    pulse_clear();
    total++;
    if (framing_err !== 2'b00) begin bad++; $display("FAIL ferr_clear: got %b want 00", framing_err); end
  endtask

  task automatic test_glitch();
    q.delete();
    @(negedge clk);
    rxd[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (200) @(negedge clk);
    total += 2;
    if (q.size() != 0) begin bad++; $display("FAIL glitch_nobyte: got %0d want 0", q.size()); end
    if ({overflow, framing_err} !== 4'b0000) begin bad++; $display("FAIL glitch_flags: got %b want 0000", {overflow, framing_err}); end
    send_frame(0, 8'h96, 1'b1);
    wait_beats(1, 100);
    total++;
    if (q.size() != 1) begin bad++; $display("FAIL glitch_after_count: got %0d want 1", q.size()); end
    if (q.size() >= 1) begin
      total++;
      if (q[0].data != 8'h96 || q[0].cyc - start_cyc[0] != LATENCY) begin
        bad++; $display("FAIL glitch_after: got %02h lat %0d want 96 lat %0d", q[0].data, q[0].cyc - start_cyc[0], LATENCY);
      end
    end
  endtask

  task automatic test_disable();
    q.delete();
    fork
      send_frame(1, 8'hF0, 1'b1);
      begin
        repeat (60) @(negedge clk);
        ch_enable[1] = 1'b0;
        repeat (5) @(negedge clk);
        ch_enable[1] = 1'b1;
      end
    join
    repeat (30) @(negedge clk);
    total += 2;
    if (q.size() != 0) begin bad++; $display("FAIL disable_nobyte: got %0d want 0", q.size()); end
    if (framing_err !== 2'b00) begin bad++; $display("FAIL disable_flags: got %b want 00", framing_err); end
    send_frame(1, 8'h0F, 1'b1);
    wait_beats(1, 100);
    total++;
    if (q.size() < 1 || q[0].data != 8'h0F || q[0].ch != 1) begin
      bad++; $display("FAIL disable_recover: got %0d beats want ch1/0f", q.size());
    end
  endtask

  task automatic test_reset_mid();
    q.delete();
    @(negedge clk);
    rxd[0] = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_if.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", out_if.out_valid); end
    reset = 1'b0;
    repeat (2000) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (50) @(negedge clk);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL midrst_nobyte: got %0d want 0", q.size()); end
    pulse_clear();
    send_frame(0, 8'h5A, 1'b1);
    wait_beats(1, 100);
    repeat (20) @(negedge clk);
    total++;
    if (q.size() != 1 || q[0].data != 8'h5A || q[0].ch != 0) begin
      bad++; $display("FAIL midrst_recover: got %0d beats want one ch0/5a", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_framing();
    test_glitch();
    test_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
